// File: rtl/pipelined_braun_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_braun_multiplier
// Description : N x N multiplier built as a Braun carry-save array with
//               Baugh-Wooley signed support. The array rows are split across
//               PIPE register stages. A final ripple-carry row then resolves
//               the result into the prod register.
//               A single global enable stalls every stage at once.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_braun_multiplier #(
  parameter int N    = 8,
  parameter int PIPE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] prod
);

  localparam int W = 2 * N;

  // Baugh-Wooley correction: +2^N and +2^(2N-1) compensate the inverted
  // MSB-row and MSB-column partial products.
  localparam logic [W-1:0] C_BW_CORR = (W'(1) << N) | (W'(1) << (W - 1));

  // Stage inputs. Index 0 comes from the ports; index p>0 comes from the
  // register of stage p-1.
  logic [W-1:0] w_s_i  [PIPE];
  logic [W-1:0] w_c_i  [PIPE];
  logic [N-1:0] w_a_i  [PIPE];
  logic [N-1:0] w_b_i  [PIPE];
  logic         w_sm_i [PIPE];
  logic         w_v_i  [PIPE];

  // Carry-save pair and valid bit leaving the last array stage.
  logic [W-1:0] w_fs;
  logic [W-1:0] w_fc;
  logic         w_fv;

  logic [W-1:0] w_sum;
  logic         w_cy;
  logic         w_en;

  logic         r_out_valid;
  logic [W-1:0] r_prod;

  // The whole pipeline advances unless a held result is being refused.
  assign w_en      = out_ready | ~r_out_valid;
  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign prod      = r_prod;

  // The correction constants seed the carry vector. Row 0 then enters as an
  // ordinary carry-save row.
  assign w_s_i[0]  = '0;
  assign w_c_i[0]  = signed_mode ? C_BW_CORR : '0;
  assign w_a_i[0]  = a;
  assign w_b_i[0]  = b;
  assign w_sm_i[0] = signed_mode;
  assign w_v_i[0]  = in_valid;

  for (genvar p = 0; p < PIPE; p++) begin : g_stage
    // Rows [LO, HI) belong to this stage. Because PIPE <= N, every stage
    // gets at least one row.
    localparam int LO = (p * N) / PIPE;
    localparam int HI = ((p + 1) * N) / PIPE;

    logic [W-1:0] w_so;
    logic [W-1:0] w_co;
    logic [W-1:0] w_pp;
    logic [W-1:0] w_x;
    logic [W-1:0] r_s;
    logic [W-1:0] r_c;
    logic         r_v;

    // Carry-save rows: the partial-product row for multiplier bit i is added
    // into the (sum, carry) pair with one full adder per column.
    always_comb begin
      w_so = w_s_i[p];
      w_co = w_c_i[p];
      w_pp = '0;
      w_x  = '0;
      for (int i = LO; i < HI; i++) begin
        w_pp = '0;
        for (int j = 0; j < N; j++) begin
          // In signed mode, partial products with exactly one MSB operand
          // bit are inverted.
          w_pp[i + j] = (w_a_i[p][j] & w_b_i[p][i])
                        ^ (w_sm_i[p] & ((i == N - 1) != (j == N - 1)));
        end
        w_x  = w_so ^ w_co ^ w_pp;
        w_co = ((w_so & w_co) | (w_so & w_pp) | (w_co & w_pp)) << 1;
        w_so = w_x;
      end
    end

    // Stage register for the carry-save pair and the valid bit. It holds
    // while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s <= '0;
        r_c <= '0;
        r_v <= 1'b0;
      end else if (w_en) begin
        r_s <= w_so;
        r_c <= w_co;
        r_v <= w_v_i[p];
      end
    end

    if (p < PIPE - 1) begin : g_fwd
      logic [N-1:0] r_a;
      logic [N-1:0] r_b;
      logic         r_sm;

      // Operands and mode travel with the item for the rows still to come.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a  <= '0;
          r_b  <= '0;
          r_sm <= 1'b0;
        end else if (w_en) begin
          r_a  <= w_a_i[p];
          r_b  <= w_b_i[p];
          r_sm <= w_sm_i[p];
        end
      end

      assign w_s_i[p+1]  = r_s;
      assign w_c_i[p+1]  = r_c;
      assign w_a_i[p+1]  = r_a;
      assign w_b_i[p+1]  = r_b;
      assign w_sm_i[p+1] = r_sm;
      assign w_v_i[p+1]  = r_v;
    end else begin : g_last
      assign w_fs = r_s;
      assign w_fc = r_c;
      assign w_fv = r_v;
    end
  end

  // Final ripple-carry row. Any carry out of bit 2N-1 is dropped, which
  // gives the modulo-2^2N result needed in both modes.
  always_comb begin
    w_cy  = 1'b0;
    w_sum = '0;
    for (int k = 0; k < W; k++) begin
      w_sum[k] = w_fs[k] ^ w_fc[k] ^ w_cy;
      w_cy     = (w_fs[k] & w_fc[k]) | (w_cy & (w_fs[k] ^ w_fc[k]));
    end
  end

  // Result register. prod only changes when a valid item lands, so it holds
  // its last value through bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_prod      <= '0;
    end else if (w_en) begin
      r_out_valid <= w_fv;
      if (w_fv) begin
        r_prod <= w_sum;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_braun_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_braun_multiplier
// Description : Self-checking bench for pipelined_braun_multiplier. It runs
//               directed N=8/PIPE=2 scenarios, an exhaustive N=4 sweep over
//               PIPE=1..4, and a random N=16/PIPE=3 stream.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipelined_braun_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // N=8, PIPE=2 instance for the directed scenarios
  logic        in_valid, out_ready, sm, in_ready, out_valid;
  logic [7:0]  a, b;
  logic [15:0] prod;

  pipelined_braun_multiplier #(.N(8), .PIPE(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(sm), .out_valid(out_valid),
    .out_ready(out_ready), .prod(prod)
  );

  // N=4 instances with PIPE=1..4, all driven by the same stream
  logic       v4, sm4, or4;
  logic [3:0] a4, b4;
  logic       ir4 [4];
  logic       ov4 [4];
  logic [7:0] p4  [4];

  for (genvar g = 0; g < 4; g++) begin : g_n4
    pipelined_braun_multiplier #(.N(4), .PIPE(g + 1)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4[g]),
      .a(a4), .b(b4), .signed_mode(sm4), .out_valid(ov4[g]),
      .out_ready(or4), .prod(p4[g])
    );
  end

  // N=16, PIPE=3 instance for the random stream
  logic        v16, sm16, or16, ir16, ov16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  pipelined_braun_multiplier #(.N(16), .PIPE(3)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16),
    .a(a16), .b(b16), .signed_mode(sm16), .out_valid(ov16),
    .out_ready(or16), .prod(p16)
  );

  // Reference product: the operands are interpreted as n-bit values
  function automatic logic [31:0] model(input int n, input logic [15:0] x,
                                        input logic [15:0] y, input logic s);
    longint sx, sy, pr;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[n-1]) sx = sx - (longint'(1) << n);
    if (s && y[n-1]) sy = sy - (longint'(1) << n);
    pr = sx * sy;
    return pr[31:0];
  endfunction

  task automatic test_reset();
    // Checked before the first clock edge, so this also covers async reset
    #2;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (prod !== 16'h0000) begin n_fail++; $display("FAIL reset_prod: got %h expected 0000", prod); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_unsigned_max();
    @(negedge clk);
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; sm = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL umax_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL umax_early1: got out_valid %b expected 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL umax_early2: got out_valid %b expected 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL umax_valid: got %b expected 1", out_valid); end
    n_checks++;
    if (prod !== 16'hFE01) begin n_fail++; $display("FAIL umax_prod: got %h expected fe01", prod); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL umax_drain: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_signed_b2b();
    // 127 * -127 = -16129 = 0xC0FF
    logic [7:0]  va [3] = '{8'h80, 8'hFF, 8'h7F};
    logic [7:0]  vb [3] = '{8'h80, 8'h01, 8'h81};
    logic [15:0] ve [3] = '{16'h4000, 16'hFFFF, 16'hC0FF};
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      if (cyc >= 3 && cyc <= 5) begin
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL signed_valid[%0d]: got %b expected 1", cyc - 3, out_valid); end
        n_checks++;
        if (prod !== ve[cyc-3]) begin n_fail++; $display("FAIL signed_prod[%0d]: got %h expected %h", cyc - 3, prod, ve[cyc-3]); end
      end else begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL signed_gap[%0d]: got out_valid %b expected 0", cyc, out_valid); end
      end
      if (cyc < 3) begin
        in_valid = 1'b1; a = va[cyc]; b = vb[cyc]; sm = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_mixed_mode();
    // 0xFE * 3: unsigned 254*3 = 762, signed -2*3 = -6
    logic [15:0] ve [4] = '{16'h02FA, 16'hFFFA, 16'h02FA, 16'hFFFA};
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc >= 3 && cyc <= 6) begin
        n_checks++;
        if (out_valid !== 1'b1 || prod !== ve[cyc-3]) begin
          n_fail++;
          $display("FAIL mixed_prod[%0d]: got valid %b prod %h expected valid 1 prod %h", cyc - 3, out_valid, prod, ve[cyc-3]);
        end
      end
      if (cyc < 4) begin
        in_valid = 1'b1; a = 8'hFE; b = 8'h03; sm = cyc[0];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [15:0] ve [8] = '{16'h0020, 16'h0022, 16'h0024, 16'h0026,
                            16'h0028, 16'h002A, 16'h002C, 16'h002E};
    int          in_idx = 0;
    int          out_idx = 0;
    logic        prev_or = 1'b1;
    logic        prev_ov = 1'b0;
    logic [15:0] prev_prod = '0;
    for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
      @(negedge clk);
      if (!prev_or && prev_ov) begin
        n_checks++;
        if (out_valid !== 1'b1 || prod !== prev_prod) begin
          n_fail++;
          $display("FAIL stall_hold: got valid %b prod %h expected valid 1 prod %h", out_valid, prod, prev_prod);
        end
      end
      out_ready = !(cyc >= 3 && cyc < 8);
      if (in_idx < 8) begin
        in_valid = 1'b1; a = 8'h10 + 8'(in_idx); b = 8'h02; sm = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready && out_valid) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (prod !== ve[out_idx]) begin n_fail++; $display("FAIL stall_order[%0d]: got %h expected %h", out_idx, prod, ve[out_idx]); end
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
      prev_or = out_ready; prev_ov = out_valid; prev_prod = prod;
    end
    n_checks++;
    if (out_idx != 8) begin n_fail++; $display("FAIL stall_count: got %0d results expected 8", out_idx); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dup[%0d]: got out_valid %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    in_valid = 1'b1; a = 8'h11; b = 8'h11; sm = 1'b0;
    @(negedge clk);
    a = 8'h22; b = 8'h03;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || prod !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrst_async: got valid %b prod %h expected valid 0 prod 0000", out_valid, prod);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flush[%0d]: got out_valid %b expected 0", i, out_valid); end
    end
    in_valid = 1'b1; a = 8'h05; b = 8'h07; sm = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early1: got out_valid %b expected 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early2: got out_valid %b expected 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || prod !== 16'h0023) begin
      n_fail++;
      $display("FAIL midrst_new: got valid %b prod %h expected valid 1 prod 0023", out_valid, prod);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_drain: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_sweep_n4();
    logic [7:0]  exp4 [512];
    int          rd [4] = '{0, 0, 0, 0};
    int          idx = 0;
    logic [31:0] m;
    for (int cyc = 0; cyc < 520; cyc++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (ov4[g] === 1'b1) begin
          n_checks++;
          if (rd[g] >= idx) begin
            n_fail++;
            $display("FAIL n4_extra[pipe %0d]: got extra result %h expected none", g + 1, p4[g]);
          end else if (p4[g] !== exp4[rd[g]]) begin
            n_fail++;
            $display("FAIL n4_prod[pipe %0d item %0d]: got %h expected %h", g + 1, rd[g], p4[g], exp4[rd[g]]);
          end
          rd[g]++;
        end
      end
      if (idx < 512) begin
        v4 = 1'b1; sm4 = idx[8]; a4 = idx[7:4]; b4 = idx[3:0];
        m = model(4, {12'b0, a4}, {12'b0, b4}, sm4);
        exp4[idx] = m[7:0];
        idx++;
      end else begin
        v4 = 1'b0;
      end
    end
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (rd[g] != 512) begin n_fail++; $display("FAIL n4_count[pipe %0d]: got %0d expected 512", g + 1, rd[g]); end
    end
  endtask

  task automatic test_random_n16();
    logic [31:0] q [$];
    logic [31:0] e;
    for (int cyc = 0; cyc < 3040; cyc++) begin
      @(negedge clk);
      if (cyc < 3000) begin
        v16  = ($urandom_range(0, 9) < 7);
        or16 = ($urandom_range(0, 9) < 7);
        a16  = 16'($urandom);
        b16  = 16'($urandom);
        sm16 = 1'($urandom_range(0, 1));
      end else begin
        v16  = 1'b0;
        or16 = 1'b1;
      end
      #1;
      if (ov16 && or16) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL n16_extra: got result %h expected none", p16);
        end else begin
          e = q.pop_front();
          if (p16 !== e) begin n_fail++; $display("FAIL n16_prod: got %h expected %h", p16, e); end
        end
      end
      if (v16 && ir16) q.push_back(model(16, a16, b16, sm16));
    end
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL n16_lost: got %0d items pending expected 0", q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; sm = 1'b0; a = '0; b = '0;
    v4 = 1'b0; sm4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0;
    v16 = 1'b0; sm16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0;
    test_reset();
    test_unsigned_max();
    test_signed_b2b();
    test_mixed_mode();
    test_back_to_back_stall();
    test_reset_midop();
    test_sweep_n4();
    test_random_n16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
